riscfsm_ctrl: RTL and testbench
===============================

# riscfsm_ctrl

Multi-cycle control FSM that sequences the RISC_FSM datapath: instruction memory, 4×8-bit register file and 8-bit ALU. It fetches 16-bit instructions through a req/ack handshake, decodes them, and drives register-file addresses, ALU opcode and write strobes. It owns the 8-bit program counter. It sits inside `top_level` between the instruction memory and the `reg_file`/`alu` instances.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset and on start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins execution from IDLE or HALT.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  8  fetch address, always equal to PC.
- imem_ack  in  1  fetch accepted; imem_data is valid in the same cycle.
- imem_data  in  16  fetched instruction.
- rf_raddr_a  out  2  register file read port A address (IR[9:8]).
- rf_raddr_b  out  2  register file read port B address (IR[7:6]).
- rf_rdata_a  in  8  port A read data, used for the BEQZ test.
- rf_waddr  out  2  write address (IR[11:10]).
- rf_wsel  out  1  write data select: 0 = ALU result, 1 = rf_imm.
- rf_imm  out  8  immediate (IR[7:0]).
- rf_we  out  1  register write strobe.
- alu_op  out  3  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT (A only).
- current_instruction  out  16  instruction register (IR).
- program_counter_out  out  8  PC.
- halted  out  1  high while in the HALT state.
- illegal  out  1  sticky flag, set by an undefined opcode.

## Operation
Instruction format:
- opcode [15:12], rd [11:10], rs1 [9:8], rs2 [7:6], imm [7:0].
- Opcodes: 0 NOP, 1 LDI (rd←imm), 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOT (rd←~rs1), 7 JMP imm, 8 BEQZ (if rs1==0, PC←imm), F HALT.
- Opcodes 9–E are illegal: treated as NOP and set `illegal`.

States:
- IDLE → FETCH on start.
- FETCH: imem_req=1. On imem_ack, IR←imem_data and go to DECODE; otherwise stay in FETCH (unbounded wait).
- DECODE: register file addresses are valid (they are combinational from IR in every state).
- EXECUTE: alu_op is valid. Branch condition is registered from rf_rdata_a==0.
- WRITEBACK:
  - rf_we=1 for LDI and ADD–NOT only.
  - PC←imm for JMP or a taken BEQZ, else PC+1. PC is 8-bit and wraps FF→00.
  - Next state is FETCH, or HALT for opcode F. HALT leaves PC unchanged.
- HALT: halted=1. start → PC←RESET_PC, illegal←0, go to FETCH. start is ignored in every other state.

alu_op mapping: opcode−2 for opcodes 2–6; 0 otherwise.

rf_wsel is 1 only for LDI.

## Timing
- Reset (rst=0, asynchronous) sets: state IDLE, PC=RESET_PC, IR=16'h0000. All other outputs are 0: imem_req, rf_we, halted, illegal, rf_wsel, alu_op.
- Reset asserted mid-instruction aborts it with no write. A pending imem_req drops immediately.
- Latency is 4 cycles per instruction when imem_ack arrives in the first FETCH cycle, plus 1 cycle per extra wait cycle.
- imem_req stays high continuously until the ack cycle. It is deasserted in the cycle after the ack. imem_addr is stable while req is high.
- rf_we is a single-cycle pulse, asserted only in WRITEBACK. The register update is visible at the next rising edge.
- PC and IR change only at the FETCH ack edge (IR) and the WRITEBACK edge (PC).
- start arriving while in FETCH/DECODE/EXECUTE/WRITEBACK has no effect.

## Test plan
- Program: LDI r0,AA (0x10AA); LDI r1,0C (0x140C); ADD r0,r0,r1 (0x2040); SUB (0x3040); AND (0x4040); OR (0x5040); NOT r0,r0 (0x6000); HALT (0xF000). Memory acks every request in the same cycle. Expected:
  - r0 sequence AA, B6, AA, 08, 0C, F3.
  - rf_we pulses exactly 7 times, each 4 cycles apart.
  - halted=1 with PC=07.
- Memory ack delayed 3 cycles on every fetch: req stays high with a stable address; the instruction takes 7 cycles; the register results are identical to the first scenario.
- JMP 0xFE at PC 0x10: PC=FE. Then NOP at FE, NOP at FF: PC wraps to 00.
- BEQZ with r2=0 → PC=imm. With r2=5 → PC=old PC+1. In both cases rf_we stays 0.
- Opcode 0xA at PC 3: illegal=1, no write, PC=4. illegal remains set until start from HALT clears it.
- rst asserted in EXECUTE of an ADD:
  - All outputs return to their reset values immediately.
  - No rf_we pulse occurs.
  - After release the block stays in IDLE until start.

Source files
------------

// File: rtl/riscfsm_ctrl.sv
// rtl/riscfsm_ctrl.sv - multi-cycle fetch/decode/execute/writeback controller for the RISC_FSM datapath
// Owns PC and IR; drives register-file addressing, ALU opcode and the write strobe.
module riscfsm_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [1:0]  rf_raddr_a,
  output logic [1:0]  rf_raddr_b,
  input  logic [7:0]  rf_rdata_a,
  output logic [1:0]  rf_waddr,
  output logic        rf_wsel,
  output logic [7:0]  rf_imm,
  output logic        rf_we,
  output logic [2:0]  alu_op,
  output logic [15:0] current_instruction,
  output logic [7:0]  program_counter_out,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  pc;
  logic [7:0]  pc_nx;
  logic [15:0] ir;
  logic        zero_q;

  logic [3:0]  opcode;
  logic        is_ldi;
  logic        is_alu;
  logic        is_jmp;
  logic        is_beqz;
  logic        is_halt;
  logic        is_bad;

  assign opcode  = ir[15:12];
  assign is_ldi  = (opcode == OP_LDI);
  assign is_alu  = (opcode >= OP_ADD) && (opcode <= OP_NOT);
  assign is_jmp  = (opcode == OP_JMP);
  assign is_beqz = (opcode == OP_BEQZ);
  assign is_halt = (opcode == OP_HALT);
  assign is_bad  = (opcode > OP_BEQZ) && (opcode < OP_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_FETCH;
      S_FETCH:     if (imem_ack) state_nx = S_DECODE;
      S_DECODE:    state_nx = S_EXECUTE;
      S_EXECUTE:   state_nx = S_WRITEBACK;
      S_WRITEBACK: state_nx = is_halt ? S_HALT : S_FETCH;
      S_HALT:      if (start) state_nx = S_FETCH;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH:     imem_req = 1'b1;
      S_WRITEBACK: rf_we    = is_ldi | is_alu;
      S_HALT:      halted   = 1'b1;
      default:     ;
    endcase
  end

  // A halting instruction retires without advancing PC so HALT reports its own address.
  always_comb begin
    pc_nx = pc;
    case (state)
      S_IDLE, S_HALT: if (start) pc_nx = RESET_PC;
      S_WRITEBACK: begin
        if (!is_halt) begin
          pc_nx = (is_jmp || (is_beqz && zero_q)) ? ir[7:0] : pc + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      zero_q  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_data;
      end
      if (state == S_EXECUTE) begin
        zero_q <= (rf_rdata_a == 8'h00);
      end
      if (state == S_HALT && start) begin
        illegal <= 1'b0;
      end else if (state == S_WRITEBACK && is_bad) begin
        illegal <= 1'b1;
      end
    end
  end

  // Opcodes ADD..NOT occupy 2..6, so the low three bits minus two give the ALU code.
  always_comb begin
    alu_op = 3'd0;
    if (is_alu) begin
      alu_op = opcode[2:0] - 3'd2;
    end
  end

  assign imem_addr           = pc;
  assign program_counter_out = pc;
  assign current_instruction = ir;
  assign rf_raddr_a          = ir[9:8];
  assign rf_raddr_b          = ir[7:6];
  assign rf_waddr            = ir[11:10];
  assign rf_imm              = ir[7:0];
  assign rf_wsel             = is_ldi;

endmodule

// File: tb/tb_riscfsm_ctrl.sv
// tb/tb_riscfsm_ctrl.sv - directed bench for riscfsm_ctrl with an instruction-level reference model
module tb_riscfsm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'hDEAD;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0]  rf_rdata_a, rf_imm;
  logic        rf_wsel, rf_we, halted, illegal;
  logic [2:0]  alu_op;
  logic [15:0] current_instruction;
  logic [7:0]  program_counter_out;

  riscfsm_ctrl #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a),
    .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .rf_imm(rf_imm), .rf_we(rf_we),
    .alu_op(alu_op), .current_instruction(current_instruction),
    .program_counter_out(program_counter_out), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_delay = 0;
  int ack_wait = 0;
  bit r0_pend = 1'b0;
  logic [15:0] mem [0:255];
  logic [7:0]  env_rf [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int          we_cycles[$];
  logic [7:0]  r0_log[$];
  logic [7:0]  r0_seq [0:5] = '{8'hAA, 8'hB6, 8'hAA, 8'h08, 8'h0C, 8'hF3};

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  // Register file and ALU that the controller sequences
  assign rf_rdata_a = env_rf[rf_raddr_a];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_we) env_rf[rf_waddr] <= rf_wsel ? rf_imm : alu(alu_op, env_rf[rf_raddr_a], env_rf[rf_raddr_b]);
  end

  // Reference: mode 0 idle, 1 running, 2 halted; phase counts cycles since the fetch was accepted.
  int          m_mode = 0;
  int          m_phase = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic        m_ill = 1'b0;
  logic [7:0]  m_rf [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0]  m_op;
  logic        exp_req, exp_we;
  logic [2:0]  exp_alu;

  assign m_op    = m_ir[15:12];
  assign exp_req = (m_mode == 1) && (m_phase == 0);
  assign exp_we  = (m_mode == 1) && (m_phase == 3) && (m_op >= 4'h1) && (m_op <= 4'h6);
  assign exp_alu = (m_op >= 4'h2 && m_op <= 4'h6) ? 3'(m_op - 4'h2) : 3'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_phase <= 0; m_pc <= 8'h00; m_ir <= 16'h0000; m_ill <= 1'b0;
    end else if (m_mode != 1) begin
      if (start) begin m_mode <= 1; m_phase <= 0; m_pc <= 8'h00; m_ill <= 1'b0; end
    end else if (m_phase == 0) begin
      if (imem_ack) begin m_ir <= imem_data; m_phase <= 1; end
    end else if (m_phase < 3) begin
      m_phase <= m_phase + 1;
    end else begin
      m_phase <= 0;
      m_pc <= m_pc + 8'd1;
      case (m_op)
        4'h1: m_rf[m_ir[11:10]] <= m_ir[7:0];
        4'h2: m_rf[m_ir[11:10]] <= m_rf[m_ir[9:8]] + m_rf[m_ir[7:6]];
        4'h3: m_rf[m_ir[11:10]] <= m_rf[m_ir[9:8]] - m_rf[m_ir[7:6]];
        4'h4: m_rf[m_ir[11:10]] <= m_rf[m_ir[9:8]] & m_rf[m_ir[7:6]];
        4'h5: m_rf[m_ir[11:10]] <= m_rf[m_ir[9:8]] | m_rf[m_ir[7:6]];
        4'h6: m_rf[m_ir[11:10]] <= ~m_rf[m_ir[9:8]];
        4'h7: m_pc <= m_ir[7:0];
        4'h8: if (m_rf[m_ir[9:8]] == 8'h00) m_pc <= m_ir[7:0];
        4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: m_ill <= 1'b1;
        4'hF: begin m_mode <= 2; m_pc <= m_pc; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: acks after ack_delay extra wait cycles
  initial forever begin
    @(negedge clk);
    if (!imem_req) begin
      ack_wait = 0; imem_ack = 1'b0; imem_data = 16'hDEAD;
    end else if (ack_wait == ack_delay) begin
      imem_ack = 1'b1; imem_data = mem[imem_addr];
    end else begin
      ack_wait++; imem_ack = 1'b0; imem_data = 16'hDEAD;
    end
  end

  // Per-cycle comparison against the reference, plus write logging
  initial forever begin
    @(negedge clk);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", program_counter_out, m_pc);
    chk("ir", current_instruction, m_ir);
    chk("rf_we", rf_we, exp_we);
    chk("halted", halted, m_mode == 2);
    chk("illegal", illegal, m_ill);
    chk("raddr_a", rf_raddr_a, m_ir[9:8]);
    chk("raddr_b", rf_raddr_b, m_ir[7:6]);
    chk("waddr", rf_waddr, m_ir[11:10]);
    chk("imm", rf_imm, m_ir[7:0]);
    chk("wsel", rf_wsel, m_op == 4'h1);
    chk("alu_op", alu_op, exp_alu);
    for (int i = 0; i < 4; i++) chk("regfile", env_rf[i], m_rf[i]);
    if (r0_pend) begin r0_log.push_back(env_rf[0]); r0_pend = 1'b0; end
    if (rf_we) begin
      we_cycles.push_back(cyc);
      if (rf_waddr == 2'd0) r0_pend = 1'b1;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int limit);
    for (int i = 0; i < limit && !halted; i++) @(negedge clk);
    chk(name, halted, 1'b1);
  endtask

  task automatic wait_pc(input string name, input logic [7:0] old, input logic [7:0] exp, input int limit);
    for (int i = 0; i < limit && program_counter_out == old; i++) @(negedge clk);
    chk(name, program_counter_out, exp);
  endtask

  task automatic run_arith(input int gap);
    int we_base, r0_base;
    we_base = we_cycles.size();
    r0_base = r0_log.size();
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_halt("arith_halt", 300);
    @(negedge clk);
    chk("arith_pc", program_counter_out, 8'h07);
    chk("arith_r1", env_rf[1], 8'h0C);
    chk("arith_we_count", we_cycles.size() - we_base, 7);
    for (int i = we_base + 1; i < we_cycles.size(); i++)
      chk("arith_we_gap", we_cycles[i] - we_cycles[i-1], gap);
    chk("arith_r0_count", r0_log.size() - r0_base, 6);
    for (int i = 0; i < 6; i++)
      if (r0_base + i < r0_log.size()) chk("arith_r0_seq", r0_log[r0_base + i], r0_seq[i]);
  endtask

  initial begin
    int we_base;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc", program_counter_out, 8'h00);
    chk("rst_ir", current_instruction, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_alu_op", alu_op, 3'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_req", imem_req, 1'b0);

    mem[0] = 16'h10AA; mem[1] = 16'h140C; mem[2] = 16'h2040; mem[3] = 16'h3040;
    mem[4] = 16'h4040; mem[5] = 16'h5040; mem[6] = 16'h6000; mem[7] = 16'hF000;
    ack_delay = 0;
    run_arith(4);
    ack_delay = 3;
    run_arith(7);
    ack_delay = 0;

    clear_mem();
    mem[8'h00] = 16'h7010; mem[8'h10] = 16'h70FE;
    pulse_start();
    wait_pc("jmp_first", 8'h00, 8'h10, 40);
    wait_pc("jmp_fe", 8'h10, 8'hFE, 40);
    mem[8'h00] = 16'hF000;
    wait_pc("nop_ff", 8'hFE, 8'hFF, 40);
    wait_pc("wrap_00", 8'hFF, 8'h00, 40);
    wait_halt("wrap_halt", 40);
    chk("wrap_halt_pc", program_counter_out, 8'h00);

    clear_mem();
    mem[8'h00] = 16'h1800; mem[8'h01] = 16'h8220;
    mem[8'h20] = 16'h1805; mem[8'h21] = 16'h8240; mem[8'h22] = 16'hF000;
    we_base = we_cycles.size();
    pulse_start();
    wait_pc("beqz_ldi", 8'h00, 8'h01, 40);
    wait_pc("beqz_taken", 8'h01, 8'h20, 40);
    wait_pc("beqz_ldi5", 8'h20, 8'h21, 40);
    wait_pc("beqz_not_taken", 8'h21, 8'h22, 40);
    wait_halt("beqz_halt", 40);
    chk("beqz_we_count", we_cycles.size() - we_base, 2);
    chk("beqz_r2", env_rf[2], 8'h05);

    clear_mem();
    mem[3] = 16'hA000; mem[4] = 16'hF000;
    we_base = we_cycles.size();
    pulse_start();
    wait_halt("ill_halt", 60);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_pc", program_counter_out, 8'h04);
    chk("ill_we_count", we_cycles.size() - we_base, 0);
    pulse_start();
    chk("ill_cleared", illegal, 1'b0);
    wait_halt("ill_halt2", 60);
    chk("ill_again", illegal, 1'b1);

    clear_mem();
    mem[0] = 16'h10AA; mem[1] = 16'h140C; mem[2] = 16'h2040; mem[3] = 16'hF000;
    we_base = we_cycles.size();
    pulse_start();
    for (int i = 0; i < 60 && current_instruction != 16'h2040; i++) @(negedge clk);
    chk("add_decoded", current_instruction, 16'h2040);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_we", rf_we, 1'b0);
    chk("arst_pc", program_counter_out, 8'h00);
    chk("arst_ir", current_instruction, 16'h0000);
    chk("arst_alu_op", alu_op, 3'd0);
    chk("arst_halted", halted, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_idle", imem_req, 1'b0);
    chk("arst_r0", env_rf[0], 8'hAA);
    chk("arst_we_count", we_cycles.size() - we_base, 2);
    pulse_start();
    wait_halt("arst_rerun", 60);
    chk("arst_rerun_r0", env_rf[0], 8'hB6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
